// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the sequential multiply/divide unit.
//               Holds the op encodings (also used by the ALU decode) and the
//               FSM state encoding.
// Contents    : op_t, c_op_* op codes, state_t, c_st_* states, op_is_div()
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  typedef logic [1:0] op_t;

  // Operation codes (all unsigned)
  localparam op_t c_op_mul   = 2'b00;  // low half of product
  localparam op_t c_op_mulhu = 2'b01;  // high half of product
  localparam op_t c_op_divu  = 2'b10;  // quotient
  localparam op_t c_op_remu  = 2'b11;  // remainder

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle = 2'd0;
  localparam state_t c_st_mult = 2'd1;
  localparam state_t c_st_div  = 2'd2;
  localparam state_t c_st_out  = 2'd3;

  // op[1] separates the divide family from the multiply family
  function automatic logic op_is_div(input op_t op);
    return op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Request/response bundle of the multiply/divide unit.
// Signals     : in_valid/in_ready/op/opa/opb  request side
//               kill                           pipeline flush
//               out_valid/result               one-cycle response
//               busy                           pipeline stall
// Modports    : master (pipeline side), slave (muldiv_seq)
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             kill;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op, opa, opb, kill,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, opa, opb, kill,
    output in_ready, out_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One radix-2 iteration, purely combinational.
//               MUL : {hi,lo} is the product register, lo holds the unused
//                     multiplier bits; add b when lo[0] is set, shift right.
//               DIV : hi is the partial remainder, lo shifts out the dividend
//                     and shifts in quotient bits (restoring subtract).
// Ports       : div            1 = divide step, 0 = multiply step
//               hi, lo, b      current register values (b = mcand/divisor)
//               hi_nxt, lo_nxt next register values
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0]   w_sum;    // carry-extended upper half after add
  logic [WIDTH:0]   w_shift;  // remainder shifted left with next dividend bit
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  always_comb begin
    w_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    w_shift = {hi, lo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, b});
    // The remainder is always below the divisor, so a successful subtract
    // fits in WIDTH bits and the top bit can be dropped.
    w_diff  = w_shift[WIDTH-1:0] - b;

    hi_nxt = '0;
    lo_nxt = '0;
    if (div) begin
      // Divisor 0 always "succeeds": quotient fills with ones and the
      // remainder ends up holding the dividend.
      if (w_ge) begin
        hi_nxt = w_diff;
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = w_shift[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = w_sum[WIDTH:1];
      lo_nxt = {w_sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Sequential unsigned multiply/divide unit. One radix-2 step
//               per clock, WIDTH steps per operation, result presented for
//               one cycle in OUT with no back-pressure.
// Ports       : clk   rising-edge clock
//               rst   asynchronous active-high reset
//               bus   muldiv_if.slave (in_valid/in_ready/op/opa/opb/kill,
//                     out_valid/result/busy)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  op_t              r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic             w_idle;
  logic             w_accept;
  logic             w_div;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_sel;

  assign w_idle   = (r_state == c_st_idle);
  // kill wins over a request presented in the same cycle
  assign w_accept = bus.in_valid && w_idle && !bus.kill;
  assign w_div    = (r_state == c_st_div);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .div    (w_div),
    .hi     (r_hi),
    .lo     (r_lo),
    .b      (r_b),
    .hi_nxt (w_hi_nxt),
    .lo_nxt (w_lo_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_op    <= c_op_mul;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
    end else if (bus.kill) begin
      r_state <= c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_cnt <= '0;
            r_op  <= bus.op;
            r_hi  <= '0;
            if (op_is_div(bus.op)) begin
              r_state <= c_st_div;
              r_lo    <= bus.opa;  // dividend
              r_b     <= bus.opb;  // divisor
            end else begin
              r_state <= c_st_mult;
              r_lo    <= bus.opb;  // multiplier
              r_b     <= bus.opa;  // multiplicand
            end
          end
        end
        c_st_mult, c_st_div: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= c_st_out;
          end
        end
        c_st_out: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // After the last step hi holds product-high/remainder and lo holds
  // product-low/quotient.
  always_comb begin
    w_sel = '0;
    case (r_op)
      c_op_mul:   w_sel = r_lo;
      c_op_mulhu: w_sel = r_hi;
      c_op_divu:  w_sel = r_lo;
      c_op_remu:  w_sel = r_hi;
      default:    w_sel = '0;
    endcase
  end

  assign bus.in_ready  = w_idle;
  assign bus.busy      = !w_idle;
  // A flush in the OUT cycle must not let the result escape.
  assign bus.out_valid = (r_state == c_st_out) && !bus.kill;
  assign bus.result    = bus.out_valid ? w_sel : '0;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Self-checking bench for muldiv_seq. The driver pushes each
//               accepted request's expected result and accept cycle into a
//               queue; a negedge monitor pops and compares on out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0] res;
    int           acc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out_valid: got result %h at cycle %0d, want no output", bus.result, cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, bus.result, e.res);
          check({e.name, "_latency"}, W'(cyc - e.acc), W'(LAT));
        end
      end else begin
        check("result_zero_when_invalid", bus.result, '0);
      end
    end
  end

  // Present a request and hold it until accepted; returns the accept cycle.
  task automatic start(input op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int acc, output bit ok);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.opa      = a;
    bus.opb      = b;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok  = bus.in_ready;
    acc = cyc;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 after %0d cycles want 1", n);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input string name, input op_t o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp);
    int acc;
    bit ok;
    start(o, a, b, acc, ok);
    if (ok) sb.push_back('{exp, acc, name});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending results want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  acc;
    int  acc1;
    int  k;
    bit  ok;

    bus.in_valid = 1'b0;
    bus.op       = c_op_mul;
    bus.opa      = '0;
    bus.opb      = '0;
    bus.kill     = 1'b0;
    rst          = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_in_ready",  bus.in_ready,  1);
    check("reset_busy",      bus.busy,      0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_result",    bus.result,    '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic function
    issue("mul_7x6", c_op_mul, 32'd7, 32'd6, 32'd42);
    drain();
    issue("mulhu_ff", c_op_mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue("mul_ff",   c_op_mul,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    issue("mulhu_2p16", c_op_mulhu, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    issue("mul_2p16",   c_op_mul,   32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    drain();
    issue("divu_100_7", c_op_divu, 32'd100, 32'd7, 32'd14);
    issue("remu_100_7", c_op_remu, 32'd100, 32'd7, 32'd2);
    issue("divu_5_0",   c_op_divu, 32'd5,   32'd0, 32'hFFFF_FFFF);
    issue("remu_5_0",   c_op_remu, 32'd5,   32'd0, 32'd5);
    issue("divu_max_1", c_op_divu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    issue("remu_max_1", c_op_remu, 32'hFFFF_FFFF, 32'd1, 32'd0);
    issue("divu_7_100", c_op_divu, 32'd7, 32'd100, 32'd0);
    drain();

    // in_valid held high with changing operands during a divide
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = c_op_divu;
    bus.opa      = 32'd100;
    bus.opb      = 32'd7;
    check("hold_first_ready", bus.in_ready, 1);
    acc1 = cyc;
    sb.push_back('{32'd14, acc1, "hold_first"});
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (bus.in_ready) break;
      if (k == 5) check("hold_in_ready_low", bus.in_ready, 0);
      bus.op  = c_op_remu;
      bus.opa = 32'd1000 + 32'(k);
      bus.opb = 32'd10;
    end
    check("hold_next_accept_cycle", W'(cyc - acc1), W'(LAT + 1));
    sb.push_back('{bus.opa % bus.opb, cyc, "hold_second"});
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain();

    // kill mid-multiply
    start(c_op_mul, 32'd5, 32'd5, acc, ok);
    while (cyc < acc + 10) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_in_ready", bus.in_ready, 1);
    check("kill_busy",     bus.busy,     0);
    repeat (40) @(negedge clk);
    issue("mul_3x3_after_kill", c_op_mul, 32'd3, 32'd3, 32'd9);
    drain();

    // kill beats a same-cycle accept
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.kill     = 1'b1;
    bus.op       = c_op_mul;
    bus.opa      = 32'd2;
    bus.opb      = 32'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.kill     = 1'b0;
    check("kill_beats_accept_busy", bus.busy, 0);
    repeat (40) @(negedge clk);

    // asynchronous reset mid-divide
    start(c_op_divu, 32'd1000, 32'd3, acc, ok);
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready",  bus.in_ready,  1);
    check("arst_busy",      bus.busy,      0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_result",    bus.result,    '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue("divu_1000_3_after_rst", c_op_divu, 32'd1000, 32'd3, 32'd333);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
